// File: rtl/stconv_unit_pkg.sv
// Shared store/load converter definitions: funct3 size codes and store FSM states.
package stconv_unit_pkg;

  // funct3 size codes; the load converter decodes the same values as LB/LH/LW.
  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

endpackage

// File: rtl/stconv_unit_lane.sv
// Combinational lane steering for a store: byte enables and shifted data for the
// low word (addressed word) and the high word (next word, used only when crossing).
module stconv_lane
  import stconv_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [3:0]  lo_be,
  output logic [3:0]  hi_be,
  output logic [31:0] lo_data,
  output logic [31:0] hi_data,
  output logic        legal
);

  logic [3:0]  base;
  logic [7:0]  m8;
  logic [63:0] w64;

  // Size mask from funct3, then shift mask and data across a two-word window.
  always_comb begin
    base  = 4'b0000;
    legal = 1'b0;
    case (funct3)
      F3_B:    begin base = 4'b0001; legal = 1'b1; end
      F3_H:    begin base = 4'b0011; legal = 1'b1; end
      F3_W:    begin base = 4'b1111; legal = 1'b1; end
      default: begin base = 4'b0000; legal = 1'b0; end
    endcase
    m8      = {4'b0000, base} << off;
    w64     = {32'h0000_0000, data} << {off, 3'b000};
    lo_be   = m8[3:0];
    hi_be   = m8[7:4];
    lo_data = w64[31:0];
    hi_data = w64[63:32];
  end

endmodule

// File: rtl/stconv_unit.sv
// Store data converter: accepts one store, issues one or two word-aligned write
// beats over mem_req/mem_ack, and reports done, illegal or misalign.
module stconv_unit
  import stconv_unit_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] ir,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        illegal,
  output logic        misalign
);

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic        misalign_q, misalign_d;
  logic [3:0]  hi_be_q, hi_be_d;
  logic [31:0] hi_data_q, hi_data_d;

  logic [3:0]  lane_lo_be, lane_hi_be;
  logic [31:0] lane_lo_data, lane_hi_data;
  logic        lane_legal;

  // Only funct3 selects the store type; the remaining IR bits are don't-care.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[31:15], ir[11:0]};

  stconv_lane u_lane (
    .funct3  (ir[14:12]),
    .off     (addr[1:0]),
    .data    (data),
    .lo_be   (lane_lo_be),
    .hi_be   (lane_hi_be),
    .lo_data (lane_lo_data),
    .hi_data (lane_hi_data),
    .legal   (lane_legal)
  );

  // Next-state and next-output logic; the high beat is captured at accept so
  // later changes on ir/addr/data cannot disturb an in-flight store.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    misalign_d  = 1'b0;
    hi_be_d     = hi_be_q;
    hi_data_d   = hi_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          if (!lane_legal) begin
            illegal_d = 1'b1;
          end else if (!SPLIT_EN && (lane_hi_be != 4'b0000)) begin
            misalign_d = 1'b1;
          end else begin
            state_d     = LO;
            req_ready_d = 1'b0;
            mem_req_d   = 1'b1;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = lane_lo_data;
            mem_be_d    = lane_lo_be;
            hi_be_d     = lane_hi_be;
            hi_data_d   = lane_hi_data;
          end
        end
      end
      LO: begin
        if (mem_ack) begin
          if (hi_be_q == 4'b0000) begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
            mem_req_d   = 1'b0;
            mem_be_d    = 4'b0000;
            done_d      = 1'b1;
          end else begin
            // Second beat follows with no bubble; address wraps modulo 2^32.
            state_d     = HI;
            mem_addr_d  = mem_addr_q + 32'd4;
            mem_wdata_d = hi_data_q;
            mem_be_d    = hi_be_q;
          end
        end
      end
      HI: begin
        if (mem_ack) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          mem_req_d   = 1'b0;
          mem_be_d    = 4'b0000;
          done_d      = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        mem_req_d   = 1'b0;
        mem_be_d    = 4'b0000;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight store immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      misalign_q  <= 1'b0;
      hi_be_q     <= 4'b0000;
      hi_data_q   <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
      misalign_q  <= misalign_d;
      hi_be_q     <= hi_be_d;
      hi_data_q   <= hi_data_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign done      = done_q;
  assign illegal   = illegal_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_stconv_unit.sv
// Testbench for stconv_unit: one split-enabled and one split-disabled instance,
// a queue-based behavioural model, per-cycle comparison and literal beat checks.
module tb_stconv_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Inputs for the SPLIT_EN=1 instance (u_*) and the SPLIT_EN=0 instance (n_*)
  logic        u_valid = 1'b0;
  logic [31:0] u_ir = '0, u_addr = '0, u_data = '0;
  logic        mem_ack = 1'b0;
  logic        n_valid = 1'b0;
  logic [31:0] n_ir = '0, n_addr = '0, n_data = '0;
  logic        n_ack = 1'b0;

  logic        u_ready, u_mreq, u_done, u_ill, u_mis;
  logic [31:0] u_maddr, u_mwdata;
  logic [3:0]  u_mbe;
  logic        n_ready, n_mreq, n_done, n_ill, n_mis;
  logic [31:0] n_maddr, n_mwdata;
  logic [3:0]  n_mbe;

  stconv_unit #(.SPLIT_EN(1'b1)) du (
    .clock(clock), .reset(reset), .req_valid(u_valid), .req_ready(u_ready),
    .ir(u_ir), .addr(u_addr), .data(u_data), .mem_req(u_mreq), .mem_ack(mem_ack),
    .mem_addr(u_maddr), .mem_wdata(u_mwdata), .mem_be(u_mbe), .done(u_done),
    .illegal(u_ill), .misalign(u_mis)
  );

  stconv_unit #(.SPLIT_EN(1'b0)) dn (
    .clock(clock), .reset(reset), .req_valid(n_valid), .req_ready(n_ready),
    .ir(n_ir), .addr(n_addr), .data(n_data), .mem_req(n_mreq), .mem_ack(n_ack),
    .mem_addr(n_maddr), .mem_wdata(n_mwdata), .mem_be(n_mbe), .done(n_done),
    .illegal(n_ill), .misalign(n_mis)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: [0]=split enabled, [1]=split disabled
  logic        e_ready[0:1], e_req[0:1], e_done[0:1], e_ill[0:1], e_mis[0:1];
  logic [31:0] e_addr[0:1], e_wdata[0:1];
  logic [3:0]  e_be[0:1];
  logic        p_v[0:1];
  logic [31:0] p_addr[0:1], p_wdata[0:1];
  logic [3:0]  p_be[0:1];

  task automatic model_reset(input int u);
    e_ready[u] = 1'b1; e_req[u] = 1'b0; e_done[u] = 1'b0; e_ill[u] = 1'b0; e_mis[u] = 1'b0;
    e_addr[u] = '0; e_wdata[u] = '0; e_be[u] = '0;
    p_v[u] = 1'b0; p_addr[u] = '0; p_wdata[u] = '0; p_be[u] = '0;
  endtask

  task automatic model_step(input int u, input logic v, input logic [31:0] ir_i,
                            input logic [31:0] a_i, input logic [31:0] d_i,
                            input logic ack_i, input bit split);
    int nbytes;
    int off;
    logic [63:0] w;
    logic [7:0] m;
    e_done[u] = 1'b0; e_ill[u] = 1'b0; e_mis[u] = 1'b0;
    if (e_req[u]) begin
      if (ack_i) begin
        if (p_v[u]) begin
          e_addr[u] = p_addr[u]; e_wdata[u] = p_wdata[u]; e_be[u] = p_be[u]; p_v[u] = 1'b0;
        end else begin
          e_req[u] = 1'b0; e_be[u] = 4'b0000; e_done[u] = 1'b1; e_ready[u] = 1'b1;
        end
      end
    end else if (e_ready[u] && v) begin
      case (ir_i[14:12])
        3'd0:    nbytes = 1;
        3'd1:    nbytes = 2;
        3'd2:    nbytes = 4;
        default: nbytes = 0;
      endcase
      off = int'(a_i[1:0]);
      if (nbytes == 0) e_ill[u] = 1'b1;
      else if ((off + nbytes > 4) && !split) e_mis[u] = 1'b1;
      else begin
        w = {32'h0, d_i} << (8 * off);
        m = 8'h00;
        for (int k = 0; k < nbytes; k++) m[off + k] = 1'b1;
        e_req[u] = 1'b1; e_ready[u] = 1'b0;
        e_addr[u] = a_i & 32'hFFFF_FFFC; e_wdata[u] = w[31:0]; e_be[u] = m[3:0];
        p_v[u] = (off + nbytes > 4);
        p_addr[u] = (a_i & 32'hFFFF_FFFC) + 32'd4; p_wdata[u] = w[63:32]; p_be[u] = m[7:4];
      end
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, u_valid, u_ir, u_addr, u_data, mem_ack, 1'b1);
      model_step(1, n_valid, n_ir, n_addr, n_data, n_ack, 1'b0);
    end
  end

  // ---------------- per-cycle compare and event counters
  int done_cnt = 0, ill_cnt = 0, mis_cnt = 0, n_req_cycles = 0;

  always @(negedge clock) begin
    chk("u.req_ready", 32'(u_ready), 32'(e_ready[0]));
    chk("u.mem_req",   32'(u_mreq),  32'(e_req[0]));
    chk("u.mem_addr",  u_maddr,      e_addr[0]);
    chk("u.mem_wdata", u_mwdata,     e_wdata[0]);
    chk("u.mem_be",    32'(u_mbe),   32'(e_be[0]));
    chk("u.done",      32'(u_done),  32'(e_done[0]));
    chk("u.illegal",   32'(u_ill),   32'(e_ill[0]));
    chk("u.misalign",  32'(u_mis),   32'(e_mis[0]));
    chk("n.req_ready", 32'(n_ready), 32'(e_ready[1]));
    chk("n.mem_req",   32'(n_mreq),  32'(e_req[1]));
    chk("n.mem_addr",  n_maddr,      e_addr[1]);
    chk("n.mem_wdata", n_mwdata,     e_wdata[1]);
    chk("n.mem_be",    32'(n_mbe),   32'(e_be[1]));
    chk("n.done",      32'(n_done),  32'(e_done[1]));
    chk("n.illegal",   32'(n_ill),   32'(e_ill[1]));
    chk("n.misalign",  32'(n_mis),   32'(e_mis[1]));
    if (u_done) done_cnt++;
    if (u_ill) ill_cnt++;
    if (n_mis) mis_cnt++;
    if (n_mreq) n_req_cycles++;
  end

  // ---------------- beat log of the split-enabled instance
  logic [31:0] log_addr[$], log_wdata[$];
  logic [3:0]  log_be[$];

  always @(posedge clock) begin
    if (!reset && u_mreq && mem_ack) begin
      log_addr.push_back(u_maddr);
      log_wdata.push_back(u_mwdata);
      log_be.push_back(u_mbe);
    end
  end

  task automatic clear_log();
    log_addr.delete(); log_wdata.delete(); log_be.delete();
  endtask

  task automatic check_beat(input string name, input int i, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
    if (i < log_addr.size()) begin
      chk({name, ".addr"}, log_addr[i], a);
      chk({name, ".be"}, 32'(log_be[i]), 32'(be));
      chk({name, ".wdata"}, log_wdata[i], wd);
    end else begin
      n_checks++; n_fail++;
      $display("FAIL %s: beat %0d missing, only %0d beats logged", name, i, log_addr.size());
    end
  endtask

  // ---------------- memory responder
  int  ack_delay = 0;
  int  wait_cnt  = 0;
  logic force_ack = 1'b0;

  always @(posedge clock) begin
    #1;
    n_ack = force_ack;
    if (force_ack) begin
      mem_ack = 1'b1;
    end else if (u_mreq) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1; wait_cnt = 0;
      end else begin
        mem_ack = 1'b0; wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0; wait_cnt = 0;
    end
  end

  // ---------------- stimulus helpers
  function automatic logic [31:0] ir_of(input logic [2:0] f3);
    logic [31:0] r;
    r = 32'hABC0_8FA3 & ~32'h0000_7000;
    r[14:12] = f3;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  // Present a request and return #1 after the edge on which it was accepted.
  task automatic send(input int u, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int t;
    if (u == 0) begin u_valid = 1'b1; u_ir = ir_of(f3); u_addr = a; u_data = d; end
    else        begin n_valid = 1'b1; n_ir = ir_of(f3); n_addr = a; n_data = d; end
    t = 0;
    while ((((u == 0) ? u_ready : n_ready) !== 1'b1) && t < 50) begin cyc(); t++; end
    if (t >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: request not accepted within 50 cycles");
    end
    cyc();
  endtask

  task automatic release_req();
    u_valid = 1'b0; n_valid = 1'b0;
    u_ir = 32'hFFFF_FFFF; u_addr = 32'hFFFF_FFFF; u_data = 32'h5A5A_5A5A;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(u_ready === 1'b1 && u_mreq === 1'b0) && t < 100) begin cyc(); t++; end
    if (t >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: unit not idle within 100 cycles");
    end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests
  initial begin
    int d0;
    int t;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.req_ready", 32'(u_ready), 32'd1);
    chk("rst.mem_req", 32'(u_mreq), 32'd0);
    chk("rst.mem_be", 32'(u_mbe), 32'd0);
    reset = 1'b0;
    cyc();

    // SB at 0x1002: single beat, done two cycles after accept
    clear_log(); ack_delay = 0; d0 = done_cnt;
    send(0, 3'b000, 32'h0000_1002, 32'hAABB_CCDD);
    release_req();
    chk("sb.beat_req", 32'(u_mreq), 32'd1);
    chk("sb.beat_done_low", 32'(u_done), 32'd0);
    cyc();
    chk("sb.done_latency", 32'(u_done), 32'd1);
    wait_idle();
    chk("sb.beats", log_addr.size(), 32'd1);
    check_beat("sb.b0", 0, 32'h0000_1000, 4'b0100, 32'hCCDD_0000);
    chk("sb.done_cnt", done_cnt - d0, 32'd1);

    // SW at 0x2001: two beats
    clear_log(); d0 = done_cnt;
    send(0, 3'b010, 32'h0000_2001, 32'h1122_3344);
    release_req();
    wait_idle();
    chk("sw.beats", log_addr.size(), 32'd2);
    check_beat("sw.b0", 0, 32'h0000_2000, 4'b1110, 32'h2233_4400);
    check_beat("sw.b1", 1, 32'h0000_2004, 4'b0001, 32'h0000_0011);
    chk("sw.done_cnt", done_cnt - d0, 32'd1);

    // SH at 0x3003 with delayed ack: outputs held while waiting
    clear_log(); ack_delay = 3; d0 = done_cnt;
    send(0, 3'b001, 32'h0000_3003, 32'h0000_BEEF);
    release_req();
    cyc(); cyc();
    chk("sh.hold_addr", u_maddr, 32'h0000_3000);
    chk("sh.hold_be", 32'(u_mbe), 32'(4'b1000));
    chk("sh.hold_wdata", u_mwdata, 32'hEF00_0000);
    wait_idle();
    chk("sh.beats", log_addr.size(), 32'd2);
    check_beat("sh.b0", 0, 32'h0000_3000, 4'b1000, 32'hEF00_0000);
    check_beat("sh.b1", 1, 32'h0000_3004, 4'b0001, 32'h0000_00BE);
    chk("sh.done_cnt", done_cnt - d0, 32'd1);

    // Illegal funct3, then ack while idle, then misalign on the no-split unit
    clear_log(); ack_delay = 0; d0 = done_cnt;
    send(0, 3'b011, 32'h0000_5008, 32'h0000_0001);
    release_req();
    chk("ill.pulse", 32'(u_ill), 32'd1);
    chk("ill.no_req", 32'(u_mreq), 32'd0);
    cyc();
    chk("ill.one_cycle", 32'(u_ill), 32'd0);
    force_ack = 1'b1;
    cyc(); cyc();
    force_ack = 1'b0;
    cyc();
    chk("idle_ack.no_req", 32'(u_mreq), 32'd0);
    send(1, 3'b010, 32'h0000_4002, 32'h1234_5678);
    release_req();
    chk("mis.pulse", 32'(n_mis), 32'd1);
    chk("mis.no_req", 32'(n_mreq), 32'd0);
    cyc(); cyc();
    chk("ill.beats", log_addr.size(), 32'd0);
    chk("ill.cnt", 32'(ill_cnt), 32'd1);
    chk("mis.cnt", 32'(mis_cnt), 32'd1);
    chk("ill.no_done", done_cnt - d0, 32'd0);

    // SW at 0xFFFFFFFE: second beat wraps to address 0
    clear_log(); d0 = done_cnt;
    send(0, 3'b010, 32'hFFFF_FFFE, 32'hA1B2_C3D4);
    release_req();
    wait_idle();
    check_beat("wrap.b0", 0, 32'hFFFF_FFFC, 4'b1100, 32'hC3D4_0000);
    check_beat("wrap.b1", 1, 32'h0000_0000, 4'b0011, 32'h0000_A1B2);
    chk("wrap.done_cnt", done_cnt - d0, 32'd1);

    // Same store with slow ack, reset while the high beat is pending
    clear_log(); ack_delay = 3; d0 = done_cnt;
    send(0, 3'b010, 32'hFFFF_FFFE, 32'hA1B2_C3D4);
    release_req();
    t = 0;
    while (u_mbe !== 4'b0011 && t < 50) begin cyc(); t++; end
    if (t >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL hi_timeout: high beat not presented within 50 cycles");
    end
    chk("rst_hi.addr_wrap", u_maddr, 32'h0000_0000);
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_hi.mem_req", 32'(u_mreq), 32'd0);
    chk("rst_hi.req_ready", 32'(u_ready), 32'd1);
    chk("rst_hi.mem_be", 32'(u_mbe), 32'd0);
    chk("rst_hi.mem_addr", u_maddr, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    ack_delay = 0;
    cyc(); cyc();
    chk("rst_hi.no_done", done_cnt - d0, 32'd0);
    chk("rst_hi.beats", log_addr.size(), 32'd1);

    // Back-to-back aligned SW with req_valid held high
    clear_log(); d0 = done_cnt;
    send(0, 3'b010, 32'h0000_5000, 32'hCAFE_F00D);
    u_addr = 32'h0000_5004; u_data = 32'h0BAD_BEEF;
    cyc();
    chk("b2b.done", 32'(u_done), 32'd1);
    chk("b2b.ready_with_done", 32'(u_ready), 32'd1);
    cyc();
    release_req();
    chk("b2b.second_req", 32'(u_mreq), 32'd1);
    chk("b2b.second_addr", u_maddr, 32'h0000_5004);
    wait_idle();
    chk("b2b.beats", log_addr.size(), 32'd2);
    check_beat("b2b.b0", 0, 32'h0000_5000, 4'b1111, 32'hCAFE_F00D);
    check_beat("b2b.b1", 1, 32'h0000_5004, 4'b1111, 32'h0BAD_BEEF);
    chk("b2b.done_cnt", done_cnt - d0, 32'd2);

    chk("nosplit.never_req", 32'(n_req_cycles), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stconv_unit.md
Name: stconv_unit

Overview:
- Store-side counterpart of the load data converter; sits between the store datapath and the data-memory write port.
- Accepts one store request (IR, byte address, register data), lane-aligns the data and generates per-byte write enables.
- Issues one or two word-aligned memory write beats over a req/ack handshake; two beats only when the store crosses a word boundary.
- Store type comes from ir[14:12], the same funct3 field the load converter decodes.

Parameters:
- SPLIT_EN, 1: 1 = split word-crossing stores into two beats; 0 = reject them with a misalign pulse and no write.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- ir  in  32  instruction register; ir[14:12] selects SB=000, SH=001, SW=010.
- addr  in  32  byte address of the store.
- data  in  32  register data; SB uses [7:0], SH uses [15:0].
- mem_req  out  1  write beat valid; held until acknowledged.
- mem_ack  in  1  memory accepted the beat on this edge.
- mem_addr  out  32  word-aligned beat address, low 2 bits always 00.
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables; bit i enables mem_wdata[8i+7:8i].
- done  out  1  one-cycle pulse: store fully written.
- illegal  out  1  one-cycle pulse: funct3 not SB/SH/SW; nothing written.
- misalign  out  1  one-cycle pulse: crossing store with SPLIT_EN=0; nothing written.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, req_ready=1, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, illegal=0, misalign=0.
- Handshake acceptance: a request is accepted on the edge where req_valid && req_ready. ir, addr and data are latched on that edge; later input changes are ignored.
- Lane computation, with off = addr[1:0]:
  - base mask: SB=0001, SH=0011, SW=1111.
  - m8 = base << off (8 bits); lo_be = m8[3:0], hi_be = m8[7:4].
  - w64 = {32'b0, data} << (8*off); lo_data = w64[31:0], hi_data = w64[63:32].
- States:
  - IDLE: on accept with illegal funct3, pulse illegal on the next cycle and stay IDLE.
  - IDLE: on accept with hi_be!=0 and SPLIT_EN=0, pulse misalign on the next cycle and stay IDLE.
  - IDLE: otherwise go to LO, with mem_req=1, mem_addr={addr[31:2],2'b00}, mem_wdata=lo_data, mem_be=lo_be, all valid from the cycle after accept.
  - LO: hold all mem_* outputs stable while mem_ack=0.
  - LO: on mem_ack with hi_be==0, go to IDLE with mem_req=0, mem_be=0 and pulse done.
  - LO: on mem_ack with hi_be!=0, go to HI with mem_addr = previous mem_addr + 4 (wraps modulo 2^32), mem_wdata=hi_data, mem_be=hi_be; mem_req stays 1 with no bubble.
  - HI: hold outputs while mem_ack=0; on mem_ack go to IDLE with mem_req=0, mem_be=0 and pulse done.
- Latency: an aligned store with immediate ack gives accept at edge N, beat at N+1, done high in cycle N+2.
- req_ready is 0 in LO and HI and returns to 1 in the same cycle done pulses, so back-to-back requests are allowed. done/illegal/misalign are never asserted together.
- mem_ack while mem_req=0 is ignored.
- Reset mid-operation aborts immediately: in-flight beats are dropped, there is no done pulse, and all outputs return to their reset values.
- Crossing cases, which give two beats when SPLIT_EN=1: SH with off=3, and SW with off≠0.

Decomposition:
- Shared package holds:
  - funct3 constants SB/SH/SW, also used by the load converter (LB/LH/LW values).
  - state encoding IDLE/LO/HI.
- One combinational sub-module, stconv_lane: inputs funct3, off, data; outputs lo_be, hi_be, lo_data, hi_data, legal.
- The FSM and output registers live in stconv_unit.

Test Plan:
- SB, addr=0x1002, data=0xAABBCCDD, ack immediate -> single beat: mem_addr=0x1000, mem_be=0100, mem_wdata[23:16]=0xDD; done two cycles after accept.
- SW, addr=0x2001, data=0x11223344, SPLIT_EN=1 -> beat1: addr 0x2000, be=1110, wdata=0x22334400; beat2: addr 0x2004, be=0001, wdata=0x00000011; then done.
- SH, addr=0x3003, data=0x0000BEEF, ack delayed 3 cycles per beat -> mem_* held stable while waiting; beat1 be=1000 byte 0xEF; beat2 addr 0x3004 be=0001 byte 0xBE; one done.
- ir[14:12]=011, and separately SW addr=0x4002 with SPLIT_EN=0 -> respectively illegal pulse and misalign pulse; mem_req never asserted.
- SW addr=0xFFFFFFFE split -> second beat mem_addr=0x00000000 (wrap); reset asserted while in HI -> mem_req=0 at once, no done, req_ready=1.
- Back-to-back: two aligned SW with req_valid held high -> second accepted in the same cycle done pulses for the first; each write lands correctly.
